pipeline_trace_unit: RTL and testbench

//  On-chip trace transmitter for the 5-stage MIPS CPU; it is the hardware producer of the per-cycle state the bench dumps.

---
 rtl/pipeline_trace_unit.sv | 168 ++++++++++++++++
 tb/tb_pipeline_trace_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_unit.sv
// pipeline_trace_unit: per-cycle trace of IF-stage PC, stall and flush, with
// cycle/stall/flush counters and a FIFO feeding a valid/ready trace stream.
// Optional build macro: TRACE_FILTER_EN -- push a record only on stall, flush,
// non-sequential PC, or the first counted cycle (counters are unaffected).
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start_i
// S_RUN   | counting and pushing trace records while start_i is high
// S_DRAIN | no counting or pushing; sink keeps popping until FIFO empty
// S_DONE  | trace finished; holds until rst_i
module pipeline_trace_unit #(
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_CYCLES = 30
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        trace_valid_o,
   input  logic        trace_ready_i,
   output logic [63:0] trace_data_o,
   output logic [31:0] cycle_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o,
   output logic        overflow_o,
   output logic        done_o
);

   localparam int          AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [31:0] LAST_C = 32'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [31:0]   cycle_cnt_q, cycle_cnt_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic [31:0]   flush_cnt_q, flush_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [63:0]   mem_q [FIFO_DEPTH];
   logic [63:0]   mem_d [FIFO_DEPTH];

   logic          counted, qualify, empty, full, pop, push;
   logic          rec_stall;
   logic [63:0]   rec;

   assign counted   = (state_q == S_RUN) && start_i;
   assign empty     = (count_q == '0);
   assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
   assign pop       = !empty && trace_ready_i;
   // flush wins over stall: a flushed cycle is recorded and counted as flush only
   assign rec_stall = stall_i && !flush_i;
   assign rec       = {cycle_cnt_q[15:0], rec_stall, flush_i, 14'b0, pc_i};
   // a pop on a full FIFO frees the slot the new record lands in
   assign push      = qualify && (!full || pop);

`ifdef TRACE_FILTER_EN
   logic [31:0] prev_pc_q, prev_pc_d;
   logic        first_q, first_d;

   // remember the last counted PC so sequential fetches can be suppressed
   always_comb begin
      prev_pc_d = prev_pc_q;
      first_d   = first_q;
      if (counted) begin
         prev_pc_d = pc_i;
         first_d   = 1'b0;
      end
   end

   // filter history registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_pc_q <= '0;
         first_q   <= 1'b1;
      end else begin
         prev_pc_q <= prev_pc_d;
         first_q   <= first_d;
      end
   end

   assign qualify = counted && (first_q || stall_i || flush_i || (pc_i != prev_pc_q + 32'd4));
`else
   assign qualify = counted;
`endif

   // next-state, counters and FIFO bookkeeping
   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      mem_d       = mem_q;

      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN: begin
            if (!start_i)
               state_d = S_DRAIN;
            else if ((MAX_CYCLES != 0) && (cycle_cnt_q == LAST_C))
               state_d = S_DRAIN;
         end
         S_DRAIN: if (empty) state_d = S_DONE;
         default: state_d = S_DONE;
      endcase

      if (counted) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
         if (flush_i)      flush_cnt_d = flush_cnt_q + 32'd1;
         else if (stall_i) stall_cnt_d = stall_cnt_q + 32'd1;
      end

      if (push) begin
         mem_d[wr_ptr_q] = rec;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      if (qualify && !push)  overflow_d = 1'b1;
   end

   // control state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cycle_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
      end
   end

   // FIFO storage; no reset needed because the output is gated by empty
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign trace_valid_o = !empty;
   assign trace_data_o  = empty ? 64'd0 : mem_q[rd_ptr_q];
   assign cycle_cnt_o   = cycle_cnt_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;
   assign overflow_o    = overflow_q;
   assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit (default build, FIFO_DEPTH=8, MAX_CYCLES=30).
module tb_pipeline_trace_unit;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, stall_i, flush_i, trace_ready_i;
   logic [31:0] pc_i;
   logic        trace_valid_o, overflow_o, done_o;
   logic [63:0] trace_data_o;
   logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] got_q [$];

   typedef struct {
      logic        stall;
      logic        flush;
      logic [31:0] pc;
      logic [63:0] exp_data;
      logic [31:0] exp_stall;
      logic [31:0] exp_flush;
   } vec_t;
   vec_t vecs [12];

   pipeline_trace_unit #(.FIFO_DEPTH(8), .MAX_CYCLES(30)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
      .stall_i(stall_i), .flush_i(flush_i), .trace_valid_o(trace_valid_o),
      .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
      .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
      .overflow_o(overflow_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   // inputs only change 1ns after posedge, so a handshake seen at negedge holds at the next edge
   always @(negedge clk_i) begin
      if (!rst_i && trace_valid_o && trace_ready_i) got_q.push_back(trace_data_o);
   end

   function automatic logic [63:0] mk_rec(input int cyc, input logic s, input logic f, input logic [31:0] pc);
      logic [15:0] c16;
      c16 = 16'(cyc);
      return {c16, s, f, 14'b0, pc};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      trace_ready_i = 1'b0; pc_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      got_q.delete();
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && !done_o; i++) tick();
      check("done_o", 64'(done_o), 64'd1);
   endtask

   task automatic check_seq(input string name, input int n, input int pc_step);
      check({name, " count"}, 64'(got_q.size()), 64'(n));
      for (int i = 0; i < n && i < got_q.size(); i++)
         check(name, got_q[i], mk_rec(i, 1'b0, 1'b0, 32'(i * pc_step)));
   endtask

   initial begin
      // reset state
      do_reset();
      check("rst valid", 64'(trace_valid_o), 64'd0);
      check("rst data", trace_data_o, 64'd0);
      check("rst counters", {cycle_cnt_o, stall_cnt_o | flush_cnt_o}, 64'd0);
      check("rst ovf/done", {62'd0, overflow_o, done_o}, 64'd0);

      // test 1: 30 sequential cycles, auto-stop, drain, done
      start_i = 1'b1; trace_ready_i = 1'b1;
      tick();
      for (int k = 0; k < 30; k++) begin
         pc_i = 32'(4 * k);
         tick();
         if (k == 0 || k == 29) check("t1 head", trace_data_o, mk_rec(k, 1'b0, 1'b0, 32'(4 * k)));
      end
      check("t1 cycle_cnt", 64'(cycle_cnt_o), 64'd30);
      pc_i = 32'd120;
      tick();
      check("t1 no count after stop", 64'(cycle_cnt_o), 64'd30);
      wait_done();
      check_seq("t1 rec", 30, 4);
      check("t1 valid after drain", 64'(trace_valid_o), 64'd0);

      // test 2: table-driven stall/flush pattern, one record in flight per cycle
      begin
         int s_run, f_run;
         s_run = 0; f_run = 0;
         for (int k = 0; k < 12; k++) begin
            vecs[k].stall = (k == 3 || k == 4 || k == 9);
            vecs[k].flush = (k == 7 || k == 9);
            vecs[k].pc    = 32'h400 + 32'(4 * k);
            if (vecs[k].flush) f_run++;
            else if (vecs[k].stall) s_run++;
            vecs[k].exp_data  = mk_rec(k, vecs[k].stall & ~vecs[k].flush, vecs[k].flush, vecs[k].pc);
            vecs[k].exp_stall = 32'(s_run);
            vecs[k].exp_flush = 32'(f_run);
         end
      end
      do_reset();
      start_i = 1'b1; trace_ready_i = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) begin
         stall_i = vecs[k].stall; flush_i = vecs[k].flush; pc_i = vecs[k].pc;
         tick();
         check($sformatf("t2 data[%0d]", k), trace_data_o, vecs[k].exp_data);
         check($sformatf("t2 stall_cnt[%0d]", k), 64'(stall_cnt_o), 64'(vecs[k].exp_stall));
         check($sformatf("t2 flush_cnt[%0d]", k), 64'(flush_cnt_o), 64'(vecs[k].exp_flush));
         if (k == 9) check("t2 both flags", 64'(trace_data_o[47:46]), 64'd1);
      end
      stall_i = 1'b0; flush_i = 1'b0; start_i = 1'b0;
      wait_done();
      check("t2 stall total", 64'(stall_cnt_o), 64'd2);
      check("t2 flush total", 64'(flush_cnt_o), 64'd2);

      // test 3: sink stalled, 9th record dropped, then drain in order
      do_reset();
      start_i = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         pc_i = 32'(4 * k);
         tick();
         if (k == 7) check("t3 ovf at full", 64'(overflow_o), 64'd0);
         if (k == 8) check("t3 ovf on drop", 64'(overflow_o), 64'd1);
         if (k == 0 || k == 9) check("t3 head stable", trace_data_o, mk_rec(0, 1'b0, 1'b0, 32'd0));
      end
      start_i = 1'b0; trace_ready_i = 1'b1;
      wait_done();
      check_seq("t3 rec", 8, 4);
      check("t3 ovf sticky", 64'(overflow_o), 64'd1);

      // test 4: push and pop on the same edge while full
      do_reset();
      start_i = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         pc_i = 32'(4 * k);
         tick();
      end
      trace_ready_i = 1'b1; pc_i = 32'd32;
      tick();
      check("t4 ovf", 64'(overflow_o), 64'd0);
      start_i = 1'b0;
      wait_done();
      check_seq("t4 rec", 9, 4);
      check("t4 cycle_cnt", 64'(cycle_cnt_o), 64'd9);

      // test 5: reset in mid-run with records queued, then restart
      do_reset();
      start_i = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         pc_i = 32'(4 * k);
         tick();
      end
      check("t5 pre-rst cnt", 64'(cycle_cnt_o), 64'd5);
      rst_i = 1'b1;
      tick();
      check("t5 rst valid", 64'(trace_valid_o), 64'd0);
      check("t5 rst cnt", 64'(cycle_cnt_o), 64'd0);
      check("t5 rst data", trace_data_o, 64'd0);
      rst_i = 1'b0; trace_ready_i = 1'b1; pc_i = 32'h100;
      tick();
      check("t5 idle no count", 64'(cycle_cnt_o), 64'd0);
      tick();
      check("t5 restart rec", trace_data_o, mk_rec(0, 1'b0, 1'b0, 32'h100));
      check("t5 restart cnt", 64'(cycle_cnt_o), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
